// File: rtl/home_inventory_pkg.sv
// -----------------------------------------------------------------------------
// home_inventory_pkg
// Shared constants, types and helpers for the home-inventory sample framer.
//   NUM_CH  : number of ADC channels that make up one frame
//   TS_W    : timestamp width
//   DATA_W  : sample width
//   CNT_W   : diagnostic counter width
//   ST_*    : framer state encoding (also visible on the framer's dbg_state)
// -----------------------------------------------------------------------------
package home_inventory_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int TS_W   = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/home_inventory_ts_gen.sv
// -----------------------------------------------------------------------------
// home_inventory_ts_gen
// Free-running timestamp: a prescaler divides clk by TS_DIV and the 32-bit
// counter advances once per prescaler wrap, rolling over from FFFF_FFFF to 0.
//   TS_DIV     : clk cycles per timestamp tick (1..65535)
//   TS_PRELOAD : value the counter restarts from after reset (normally 0;
//                a non-zero value lets bring-up reach the rollover quickly)
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset (prescaler and counter restart)
//   ts  : current timestamp
// -----------------------------------------------------------------------------
module home_inventory_ts_gen
  import home_inventory_pkg::*;
#(
  parameter int unsigned     TS_DIV     = 1,
  parameter logic [TS_W-1:0] TS_PRELOAD = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [TS_W-1:0] ts
);

  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TS_DIV - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            tick;

  always_comb begin
    // With TS_DIV=1 the prescaler sits at 0 and ticks every cycle.
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
    ts_d  = tick ? ts_q + TS_W'(1) : ts_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      ts_q  <= TS_PRELOAD;
    end else begin
      pre_q <= pre_d;
      ts_q  <= ts_d;
    end
  end

  assign ts = ts_q;

endmodule

// File: rtl/home_inventory_sample_framer.sv
// -----------------------------------------------------------------------------
// home_inventory_sample_framer
// Gathers per-channel ADC capture words into one timestamped frame and strobes
// the frame to the event detector.
//
// Handshake: a word transfers on any clk edge where in_valid && in_ready.
// in_ready depends only on state (low only during the one-cycle EMIT), never
// on in_valid; the upstream may hold or change in_valid freely.
//
// Frame flow: the first kept word in IDLE latches the timestamp and starts the
// timeout counter. A frame completes when every channel in the current ch_mask
// has been received (re-checked every cycle, so shrinking the mask can finish
// a frame) or closes as partial when the timeout expires. The output registers
// are loaded on the closing edge, so sample_valid rises the cycle after the
// last word and coincides with the EMIT state.
//
// Parameters:
//   TS_DIV        : clk cycles per timestamp tick (1..65535)
//   FRAME_TIMEOUT : cycles from the first word to a forced close (>= 2)
//   TS_PRELOAD    : timestamp restart value after reset (normally 0)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : capture word handshake
//   in_ch, in_data      : channel index and sample value of the word
//   ch_mask             : channels that must be present for a full frame
//   sample_valid        : one-cycle frame strobe
//   ts_now              : timestamp of the first word of the strobed frame
//   sample_ch0..7       : framed samples (absent channels keep old values)
//   frame_partial       : strobed frame was closed by timeout
//   dup_count           : saturating count of overwritten staged words
//   timeout_count       : saturating count of timeout-closed frames
//   dbg_state           : current framer state (ST_* encoding)
// -----------------------------------------------------------------------------
module home_inventory_sample_framer
  import home_inventory_pkg::*;
#(
  parameter int unsigned     TS_DIV        = 1,
  parameter int unsigned     FRAME_TIMEOUT = 4096,
  parameter logic [TS_W-1:0] TS_PRELOAD    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              sample_valid,
  output logic [TS_W-1:0]   ts_now,
  output logic [DATA_W-1:0] sample_ch0,
  output logic [DATA_W-1:0] sample_ch1,
  output logic [DATA_W-1:0] sample_ch2,
  output logic [DATA_W-1:0] sample_ch3,
  output logic [DATA_W-1:0] sample_ch4,
  output logic [DATA_W-1:0] sample_ch5,
  output logic [DATA_W-1:0] sample_ch6,
  output logic [DATA_W-1:0] sample_ch7,
  output logic              frame_partial,
  output logic [CNT_W-1:0]  dup_count,
  output logic [CNT_W-1:0]  timeout_count,
  output logic [1:0]        dbg_state
);

  localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(FRAME_TIMEOUT - 1);

  logic [TS_W-1:0] ts;

  home_inventory_ts_gen #(
    .TS_DIV     (TS_DIV),
    .TS_PRELOAD (TS_PRELOAD)
  ) u_ts_gen (
    .clk (clk),
    .rst (rst),
    .ts  (ts)
  );

  logic [1:0]      state_q, state_d;
  ch_vec_t         got_q, got_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [TS_W-1:0] frame_ts_q, frame_ts_d;
  sample_t         stage_q [NUM_CH];
  sample_t         stage_d [NUM_CH];
  sample_t         sample_q [NUM_CH];
  sample_t         sample_d [NUM_CH];
  logic [TS_W-1:0] ts_now_q, ts_now_d;
  logic            valid_q, valid_d;
  logic            partial_q, partial_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic [CNT_W-1:0] tout_q, tout_d;

  logic    accept;
  logic    keep;
  ch_vec_t new_bit;
  ch_vec_t got_all;
  logic    complete;
  logic    close;
  logic    close_partial;

  assign in_ready = (state_q != ST_EMIT);

  always_comb begin
    state_d    = state_q;
    got_d      = got_q;
    tcnt_d     = tcnt_q;
    frame_ts_d = frame_ts_q;
    stage_d    = stage_q;
    sample_d   = sample_q;
    ts_now_d   = ts_now_q;
    valid_d    = 1'b0;
    partial_d  = partial_q;
    dup_d      = dup_q;
    tout_d     = tout_q;
    close         = 1'b0;
    close_partial = 1'b0;

    accept  = in_valid && in_ready;
    // Words for channels outside the mask are consumed but ignored.
    keep    = accept && ch_mask[in_ch];
    new_bit = keep ? (ch_vec_t'(1) << in_ch) : '0;
    got_all = got_q | new_bit;
    // An empty mask must never complete, otherwise every cycle would strobe.
    complete = (ch_mask != '0) && ((got_all & ch_mask) == ch_mask);

    if (keep) begin
      stage_d[in_ch] = in_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (keep) begin
          frame_ts_d = ts;
          got_d      = new_bit;
          // The cycle the first word arrives counts as cycle 0.
          tcnt_d     = TW'(1);
          if (complete) begin
            close = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (keep && got_q[in_ch]) begin
          dup_d = sat_inc(dup_q);
        end
        got_d = got_all;
        // Completion wins over a timeout landing on the same cycle.
        if (complete) begin
          close = 1'b1;
        end else if (tcnt_q == TCNT_LAST) begin
          close         = 1'b1;
          close_partial = 1'b1;
          tout_d        = sat_inc(tout_q);
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_EMIT: begin
        got_d   = '0;
        tcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        got_d   = '0;
        tcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Closing edge: publish the frame so the strobe lines up with EMIT.
    if (close) begin
      state_d   = ST_EMIT;
      got_d     = got_all;
      valid_d   = 1'b1;
      partial_d = close_partial;
      ts_now_d  = frame_ts_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (got_all[k]) begin
          sample_d[k] = stage_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      got_q      <= '0;
      tcnt_q     <= '0;
      frame_ts_q <= '0;
      ts_now_q   <= '0;
      valid_q    <= 1'b0;
      partial_q  <= 1'b0;
      dup_q      <= '0;
      tout_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        stage_q[k]  <= '0;
        sample_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      got_q      <= got_d;
      tcnt_q     <= tcnt_d;
      frame_ts_q <= frame_ts_d;
      ts_now_q   <= ts_now_d;
      valid_q    <= valid_d;
      partial_q  <= partial_d;
      dup_q      <= dup_d;
      tout_q     <= tout_d;
      for (int k = 0; k < NUM_CH; k++) begin
        stage_q[k]  <= stage_d[k];
        sample_q[k] <= sample_d[k];
      end
    end
  end

  assign sample_valid  = valid_q;
  assign ts_now        = ts_now_q;
  assign frame_partial = partial_q;
  assign dup_count     = dup_q;
  assign timeout_count = tout_q;
  assign dbg_state     = state_q;
  assign sample_ch0    = sample_q[0];
  assign sample_ch1    = sample_q[1];
  assign sample_ch2    = sample_q[2];
  assign sample_ch3    = sample_q[3];
  assign sample_ch4    = sample_q[4];
  assign sample_ch5    = sample_q[5];
  assign sample_ch6    = sample_q[6];
  assign sample_ch7    = sample_q[7];

endmodule
